// File: rtl/trdb_pkg.sv
// Shared trace-debug types and constants for the word buffer.
package trdb_pkg;

  localparam int         TRDB_WORD_LEN = 32;
  // Header tag carried in bits [6:5] of every WORD0 word.
  localparam logic [1:0] TRDB_HDR_TAG  = 2'b01;

  typedef enum logic {
    WB_RUN  = 1'b0,
    WB_DROP = 1'b1
  } trdb_wb_state_e;

  typedef enum logic {
    PH_WORD0 = 1'b0,
    PH_WORD1 = 1'b1
  } trdb_word_phase_e;

endpackage

// File: rtl/trdb_word_fifo_mem.sv
// DEPTH x 32 register array: one synchronous write port and one
// combinational read port, so the head word is visible without latency.
module trdb_word_fifo_mem
  import trdb_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [AW-1:0]            waddr_i,
  input  logic [TRDB_WORD_LEN-1:0] wdata_i,
  input  logic [AW-1:0]            raddr_i,
  output logic [TRDB_WORD_LEN-1:0] rdata_o
);

  logic [TRDB_WORD_LEN-1:0] mem_q [DEPTH];

  // Storage write; contents need no reset because fill gates visibility.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/trdb_word_buffer.sv
// Trace word buffer: absorbs one word per cycle from the aligner (no
// backpressure), drains over valid/ready, and on overflow drops words
// until it can resynchronise on a WORD0 header with room for a full pair.
// Optional macro TRDB_WORD_BUFFER_WATERMARK_EN enables the watermark irq_o.
//
// Handshake: the head word transfers on every cycle where valid_o && ready_i;
// valid_o never depends on ready_i and data_o holds while valid_o && !ready_i.
module trdb_word_buffer
  import trdb_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int WATERMARK = 12
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [TRDB_WORD_LEN-1:0]   data_i,
  input  logic                       valid_i,
  input  logic                       flush_i,
  output logic [TRDB_WORD_LEN-1:0]   data_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH):0]     fill_o,
  output logic                       overflow_o,
  output logic [15:0]                drop_cnt_o,
  output logic                       irq_o
);

  localparam int             AW      = $clog2(DEPTH);
  localparam int             FW      = AW + 1;
  localparam logic [FW-1:0]  DEPTH_F = FW'(DEPTH);

  trdb_wb_state_e           state_q, state_d;
  trdb_word_phase_e         phase_q;
  logic [AW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [FW-1:0]            fill_q, fill_d, free_w;
  logic                     overflow_q;
  logic [15:0]              drop_cnt_q;
  logic                     push, pop, drop, full, empty;
  logic [TRDB_WORD_LEN-1:0] rdata;

  trdb_word_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk_i   (clk_i),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  assign empty = (fill_q == '0);
  assign full  = (fill_q == DEPTH_F);

  // Push/pop/drop decision and next state; flush suppresses all traffic.
  always_comb begin
    pop     = !empty && ready_i && !flush_i;
    free_w  = DEPTH_F - fill_q + FW'(pop);
    push    = 1'b0;
    drop    = 1'b0;
    state_d = state_q;
    if (!flush_i && valid_i) begin
      case (state_q)
        WB_RUN: begin
          if (!full || pop) begin
            push = 1'b1;
          end else begin
            drop    = 1'b1;
            state_d = WB_DROP;
          end
        end
        WB_DROP: begin
          // Only restart on a header word with room for its payload too.
          if (phase_q == PH_WORD0 && free_w >= FW'(2)) begin
            push    = 1'b1;
            state_d = WB_RUN;
          end else begin
            drop = 1'b1;
          end
        end
        default: state_d = WB_RUN;
      endcase
    end
    fill_d = fill_q + FW'(push) - FW'(pop);
  end

  // FSM, pointers, occupancy, phase tracker and drop accounting.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      state_q    <= WB_RUN;
      phase_q    <= PH_WORD0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      if (valid_i) phase_q <= (phase_q == PH_WORD0) ? PH_WORD1 : PH_WORD0;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  assign valid_o    = !empty;
  assign data_o     = empty ? '0 : rdata;
  assign fill_o     = fill_q;
  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_cnt_q;

`ifdef TRDB_WORD_BUFFER_WATERMARK_EN
  logic irq_q;

  // Watermark interrupt tracks the next-cycle fill level.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) irq_q <= 1'b0;
    else                  irq_q <= (fill_d >= FW'(WATERMARK));
  end

  assign irq_o = irq_q;
`else
  logic unused_watermark;
  assign unused_watermark = ^WATERMARK;
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_trdb_word_buffer.sv
// Bench for trdb_word_buffer: directed scenarios then random traffic, all
// checked against a queue-based reference model of the buffer's rules.
module tb_trdb_word_buffer;
  import trdb_pkg::*;

  localparam int DEPTH     = 16;
  localparam int WATERMARK = 12;
`ifdef TRDB_WORD_BUFFER_WATERMARK_EN
  localparam bit WM_ON = 1'b1;
`else
  localparam bit WM_ON = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] data_i = '0;
  logic        valid_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        ready_i = 1'b0;
  logic [31:0] data_o;
  logic        valid_o;
  logic [4:0]  fill_o;
  logic        overflow_o;
  logic [15:0] drop_cnt_o;
  logic        irq_o;

  always #5 clk_i = ~clk_i;

  trdb_word_buffer #(.DEPTH(DEPTH), .WATERMARK(WATERMARK)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .flush_i    (flush_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .fill_o     (fill_o),
    .overflow_o (overflow_o),
    .drop_cnt_o (drop_cnt_o),
    .irq_o      (irq_o)
  );

  // ---------------- scoreboard / reference model ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  bit          m_ovf;
  int          m_cnt;
  bit          m_drop;   // currently discarding words
  bit          m_phase;  // 0 = next valid word is WORD0

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_ovf   = 0;
    m_cnt   = 0;
    m_drop  = 0;
    m_phase = 0;
  endtask

  // One clock of the buffer's rules, in terms of a word queue.
  task automatic model_step(input bit v, input logic [31:0] d, input bit r, input bit f);
    bit pop;
    bit store;
    if (f) begin
      model_clear();
      return;
    end
    pop   = (exp_q.size() > 0) && r;
    store = 0;
    if (v) begin
      if (!m_drop) store = (exp_q.size() < DEPTH) || pop;
      else         store = (m_phase == 0) && (DEPTH - exp_q.size() + int'(pop) >= 2);
      if (store) m_drop = 0;
      else begin
        m_drop = 1;
        m_ovf  = 1;
        if (m_cnt < 65535) m_cnt++;
      end
      m_phase = ~m_phase;
    end
    if (pop)   void'(exp_q.pop_front());
    if (store) exp_q.push_back(d);
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_d;
    bit          exp_irq;
    exp_d   = (exp_q.size() > 0) ? exp_q[0] : 32'h0;
    exp_irq = WM_ON && (exp_q.size() >= WATERMARK);
    chk({tag, ".data"},  data_o,              exp_d);
    chk({tag, ".valid"}, 32'(valid_o),        32'(exp_q.size() > 0));
    chk({tag, ".fill"},  32'(fill_o),         32'(exp_q.size()));
    chk({tag, ".ovf"},   32'(overflow_o),     32'(m_ovf));
    chk({tag, ".cnt"},   32'(drop_cnt_o),     32'(m_cnt));
    chk({tag, ".irq"},   32'(irq_o),          32'(exp_irq));
    chk({tag, ".state"}, 32'(dut.state_q),    32'(m_drop ? WB_DROP : WB_RUN));
    chk({tag, ".phase"}, 32'(dut.phase_q),    32'(m_phase ? PH_WORD1 : PH_WORD0));
  endtask

  // ---------------- driver ----------------
  function automatic logic [31:0] gen_word();
    logic [31:0] w;
    logic [31:0] id;
    w  = $urandom();
    id = $urandom_range(0, 31);
    if (m_phase == 0) w[6:0] = {TRDB_HDR_TAG, id[4:0]};
    return w;
  endfunction

  task automatic step(input string tag, input bit v, input logic [31:0] d,
                      input bit r, input bit f);
    valid_i = v;
    data_i  = d;
    ready_i = r;
    flush_i = f;
    @(posedge clk_i);
    model_step(v, d, r, f);
    #1;
    check_all(tag);
  endtask

  task automatic push_n(input string tag, input int n, input bit r);
    for (int i = 0; i < n; i++) step(tag, 1'b1, gen_word(), r, 1'b0);
  endtask

  task automatic idle_n(input string tag, input int n, input bit r);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 32'h0, r, 1'b0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    model_clear();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check_all("reset");
    rst_i = 1'b0;

    // In-order drain with first-word fall-through.
    step("t1p0", 1'b1, 32'h0000_0021, 1'b0, 1'b0);
    chk("t1_first_word", data_o, 32'h0000_0021);
    step("t1p1", 1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
    step("t1p2", 1'b1, 32'h5555_0002, 1'b0, 1'b0);
    chk("t1_fill3", 32'(fill_o), 32'd3);
    idle_n("t1pop", 3, 1'b1);
    chk("t1_empty", 32'(valid_o), 32'd0);

    // Overflow into DROP, then resync only on a WORD0 with room.
    step("t2flush", 1'b0, 32'h0, 1'b0, 1'b1);
    push_n("t2pre", 1, 1'b0);
    idle_n("t2prepop", 1, 1'b1);
    push_n("t2fill", DEPTH, 1'b0);
    push_n("t2over", 4, 1'b0);
    chk("t2_cnt4", 32'(drop_cnt_o), 32'd4);
    chk("t2_ovf", 32'(overflow_o), 32'd1);
    chk("t2_drop_state", 32'(dut.state_q), 32'(WB_DROP));
    idle_n("t3pop", 3, 1'b1);
    push_n("t3w1", 1, 1'b0);
    chk("t3_cnt5", 32'(drop_cnt_o), 32'd5);
    push_n("t3w0", 1, 1'b0);
    chk("t3_run", 32'(dut.state_q), 32'(WB_RUN));
    chk("t3_fill14", 32'(fill_o), 32'd14);

    // Full buffer with simultaneous push and pop across pointer wrap.
    step("t4flush", 1'b0, 32'h0, 1'b0, 1'b1);
    push_n("t4fill", DEPTH, 1'b0);
    push_n("t4both", 8, 1'b1);
    chk("t4_fill16", 32'(fill_o), 32'd16);
    chk("t4_nodrop", 32'(drop_cnt_o), 32'd0);

    // Flush wins over a concurrent push.
    step("t5flush", 1'b0, 32'h0, 1'b0, 1'b1);
    push_n("t5fill", 5, 1'b0);
    step("t5flushv", 1'b1, gen_word(), 1'b1, 1'b1);
    chk("t5_fill0", 32'(fill_o), 32'd0);
    chk("t5_valid0", 32'(valid_o), 32'd0);

    // Watermark rise and fall.
    push_n("t6fill", WATERMARK - 1, 1'b0);
    chk("t6_irq_below", 32'(irq_o), 32'd0);
    push_n("t6wm", 1, 1'b0);
    chk("t6_irq_at", 32'(irq_o), 32'(WM_ON));
    idle_n("t6pop", 1, 1'b1);
    chk("t6_irq_fall", 32'(irq_o), 32'd0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 600; i++) begin
      step("rnd", $urandom_range(0, 3) != 0, gen_word(),
           $urandom_range(0, 2) == 0, $urandom_range(0, 149) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
